// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 7 data (LSB first), 1 even-parity, 1 stop bit.
// Each bit is held on the registered tx line for CLKS_PER_BIT clock cycles.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [2:0]        r_idx,   w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par,   w_par_nxt;
  logic              r_tx,    w_tx_nxt;
  logic              w_bit_done;
  logic              w_accept;

  assign w_bit_done = (r_cnt == CNT_LAST);
  assign w_accept   = tx_valid && (r_state == IDLE);

  // The next tx value is computed alongside the next state, so the line
  // changes on the same edge the state does and needs no decode glitch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (w_accept) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
          w_par_nxt   = ^tx_data;
          w_idx_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter and counterpart of the team's UART receiver. Shares the same 10-bit frame: 1 start bit, 7 data bits, 1 even-parity bit, 1 stop bit.
- Accepts a 7-bit word over a valid/ready handshake. Serialises it LSB first on a single line at a rate set by a clock divider.
- Sits between on-chip logic and the pad driving the link into a uart_rx.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- DATA_W, 7, data bits per frame; fixed at 7 for compatibility with the receiver and not to be overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  7  word to send; sampled only on an accepted handshake.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle high; registered output.
- busy  output  1  high while a frame is on the line (start through last stop cycle).

Behaviour:
- Reset (asynchronous, active-high) sets: tx=1, tx_ready=1, busy=0, state IDLE, all counters 0.
- Reset asserted mid-frame:
  - tx returns to 1 immediately; the frame is aborted and the latched word is discarded.
  - No frame resumes after reset deasserts.
- States are IDLE, START, DATA, PARITY, STOP. tx_ready=1 only in IDLE; busy=1 in every other state.
- Handshake:
  - A word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into a 7-bit shift register on that edge.
  - Parity is computed as the XOR of the 7 data bits and latched on the same edge.
  - tx_valid while tx_ready=0 is ignored: no queueing and no error.
  - tx_data changes after acceptance have no effect on the frame in flight.
- Latency: the start bit (tx=0) appears on the cycle immediately after the accepting edge.
- Bit timing:
  - A baud counter of width clog2(CLKS_PER_BIT) counts 0..CLKS_PER_BIT-1 within each bit.
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles.
  - The state advances when the counter reaches CLKS_PER_BIT-1; the counter wraps to 0 on every state change.
- Transitions:
  - IDLE->START on accept.
  - START->DATA after one bit time.
  - DATA sends shift-register bit 0, shifts right each bit time, and has a 3-bit index counting 0..6. DATA->PARITY after the bit-time ending index 6.
  - PARITY drives the latched even-parity bit (XOR of data bits; total ones in data+parity is even). PARITY->STOP after one bit time.
  - STOP drives tx=1. STOP->IDLE after one bit time.
- Frame length: exactly 10*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
- Back-to-back frames:
  - The cycle after the last stop cycle is IDLE (tx=1, tx_ready=1).
  - If tx_valid is high on that cycle, the next start bit follows immediately. The minimum inter-frame idle is therefore 1 cycle.
- Line encoding: tx is glitch-free and registered; it never toggles within a bit time.

Test Plan:
- Reset, CLKS_PER_BIT=4, idle 20 cycles -> tx=1, tx_ready=1, busy=0 throughout.
- Send 7'h55 with CLKS_PER_BIT=4:
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, parity 0, stop).
  - busy high for exactly 40 cycles; tx_ready low for the same 40 cycles.
- Send 7'h01 then 7'h7F with tx_valid held high:
  - Both frames use parity bit 1.
  - The second start bit begins 1 cycle after the first stop bit ends.
  - Total 81 cycles from first start to second stop end.
- Accept 7'h00, then drive tx_data=7'h7F with tx_valid=1 during the frame -> line carries data 0000000 and parity 0; the 7'h7F word is not sent until tx_ready returns.
- Assert rst asynchronously mid-way through data bit 3 -> tx goes to 1 without waiting for a clock edge, busy=0, tx_ready=1; no further frame bits after release.
- Loopback: connect tx to a uart_rx at the same bit rate and send 7'h2A -> receiver captures 7'h2A with correct_frame=1.
